// File: rtl/simon_seq.sv
// Iterative Simon 128/128 encryptor: one round per clock with an on-the-fly key
// schedule, start/ready accept handshake and valid/ready result handshake.
module simon_seq #(
  parameter int ROUNDS = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  output logic         ready_o,
  input  logic [127:0] pt_i,
  input  logic [127:0] k0_i,
  output logic         busy_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] ct_o,
  output logic [6:0]   round_o
);

  // Handshakes: a start is taken on an edge where start_i && ready_o; a result
  // is consumed on an edge where valid_o && ready_i, and ct_o holds until then.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [61:0] Z2   = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [63:0] C    = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [6:0]  LAST = 7'(ROUNDS - 1);

  state_t         state, state_nxt;
  logic [63:0]    x, y, ka, kb;
  logic [6:0]     round;
  logic [127:0]   ct;

  logic [63:0]    f, tmp, knew, x_nxt;
  logic [5:0]     z_idx, z_pos;
  logic           z_bit;
  logic           last;

  // z2 index 0 is the leftmost character, i.e. the MSB of Z2.
  assign z_idx = (round >= 7'd62) ? 6'(round - 7'd62) : round[5:0];
  assign z_pos = 6'd61 - z_idx;
  assign z_bit = Z2[z_pos];

  assign f     = ({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]};
  assign x_nxt = y ^ f ^ ka;
  assign tmp   = {kb[2:0], kb[63:3]} ^ {kb[3:0], kb[63:4]};
  assign knew  = C ^ {63'd0, z_bit} ^ ka ^ tmp;
  assign last  = (round == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (last)    state_nxt = DONE;
      DONE:    if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      ka    <= '0;
      kb    <= '0;
      round <= '0;
      ct    <= '0;
    end else if (state == IDLE && start_i) begin
      x     <= pt_i[127:64];
      y     <= pt_i[63:0];
      ka    <= k0_i[63:0];
      kb    <= k0_i[127:64];
      round <= '0;
    end else if (state == RUN) begin
      x     <= x_nxt;
      y     <= x;
      ka    <= kb;
      kb    <= knew;
      round <= round + 7'd1;
      // Capture the result separately so ct_o stays frozen outside RUN->DONE.
      if (last) ct <= {x_nxt, x};
    end
  end

  assign ready_o = (state == IDLE);
  assign busy_o  = (state == RUN);
  assign valid_o = (state == DONE);
  assign ct_o    = ct;
  assign round_o = round;

endmodule

// File: doc/simon_seq.md
Name: simon_seq

Overview:
- Handshake-driven iterative Simon 128/128 encryption engine for the crypto subsystem.
- Accepts one plaintext/key pair per transaction and runs all rounds on a single round datapath, one round per clock, with an on-the-fly key schedule.
- Holds the ciphertext until the consumer accepts it.
- Gives software and bus front-ends a start/done-controlled encryptor in place of a free-running core.

Parameters:
ROUNDS, 68, number of Simon rounds executed; 68 for Simon 128/128, legal range 2..68.

Ports:
clk      input   1    clock, all state updates on rising edge
rst_n    input   1    synchronous active-low reset
start_i  input   1    request to encrypt; sampled only when ready_o=1
ready_o  output  1    engine idle, able to accept start_i
pt_i     input   128  plaintext; x word = [127:64], y word = [63:0]
k0_i     input   128  key; k1 = [127:64], k0 = [63:0]
busy_o   output  1    rounds in progress
valid_o  output  1    ct_o holds a finished ciphertext
ready_i  input   1    consumer accepts ct_o when valid_o=1
ct_o     output  128  ciphertext x||y, stable while valid_o=1
round_o  output  7    current round index, for debug

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; ready_o=1; busy_o=0; valid_o=0; ct_o=0; round_o=0.
- Reset has priority over every other event, including mid-RUN and mid-DONE; an in-flight result is discarded.
- State IDLE:
  - ready_o=1.
  - Handshake start_i&&ready_o at edge t: latch x=pt_i[127:64], y=pt_i[63:0], ka=k0_i[63:0], kb=k0_i[127:64]; round=0; go to RUN.
  - pt_i and k0_i are don't-care after t.
- State RUN (busy_o=1, ready_o=0, valid_o=0), each edge:
  - x <= y ^ f(x) ^ ka; y <= x.
  - f(x) = (rotl1(x) & rotl8(x)) ^ rotl2(x).
  - Key schedule:
    - tmp = rotr3(kb) ^ rotr4(kb).
    - knew = 64'hFFFF_FFFF_FFFF_FFFC ^ z2[round mod 62] ^ ka ^ tmp; the z bit is XORed into bit 0.
    - ka <= kb; kb <= knew.
  - round <= round+1.
  - When round==ROUNDS-1, the update is the last round; go to DONE with valid_o=1 registered.
- z2 sequence, index 0 first: 10101111011100000011010010011000101000010001111110010110110011 (62 bits).
- Latency: start accepted at edge t → valid_o=1 after edge t+ROUNDS (68 cycles for the default).
- State DONE:
  - valid_o=1; ct_o={x,y} stays stable; busy_o=0; ready_o=0.
  - valid_o&&ready_i at an edge: valid_o<=0; go to IDLE.
  - The next start is accepted no earlier than the following edge, so minimum issue interval = ROUNDS+2 cycles.
  - valid_o stays high indefinitely while ready_i=0; no data loss.
- start_i asserted while ready_o=0 is ignored: not queued, no error.
- ready_i while valid_o=0 has no effect.
- round_o shows the round counter. In IDLE it holds the last value; it is cleared to 0 on accept.
- ct_o changes only on reset or at the RUN→DONE edge. It retains the last ciphertext in IDLE.
- Single clock domain, no combinational path from inputs to outputs except none; all outputs are registered or state-decoded.

Test Plan:
1. Known-answer test:
   - Stimulus: k0_i=0f0e0d0c0b0a0908_0706050403020100, pt_i=63736564_20737265_6c6c6576_61727420, start pulse.
   - Required: after 68 cycles valid_o=1, ct_o=49681b1e1e54fe3f_65aa832af84e0bbc, busy_o low in the same cycle.
2. Backpressure:
   - Stimulus: hold ready_i=0 for 20 cycles after valid_o rises.
   - Required: ct_o and valid_o stable throughout; ready_o=0; a start_i pulse in this window is ignored. Then ready_i=1 for one cycle → valid_o=0, ready_o=1 on the next cycle.
3. Start during RUN:
   - Stimulus: pulse start_i with a different pt_i at round 30.
   - Required: result still equals the test 1 ciphertext; round_o counts monotonically 0..67 without restarting.
4. Reset mid-operation:
   - Stimulus: drop rst_n for one edge at round 40.
   - Required: next cycle ready_o=1, busy_o=0, valid_o=0, ct_o=0. A fresh start then reproduces the test 1 result exactly 68 cycles later.
5. Back-to-back:
   - Stimulus: start_i held high and ready_i held high continuously with the test 1 vector.
   - Required: valid_o pulses for exactly one cycle every 70 cycles, each time with ct_o=49681b1e1e54fe3f_65aa832af84e0bbc.
6. Input isolation:
   - Stimulus: randomize pt_i and k0_i every cycle after the accept edge of test 1.
   - Required: ct_o equals the test 1 ciphertext, proving inputs are latched only at accept.
